// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register file.
// Macro REG_FILE_BYPASS_EN enables write-to-read forwarding on same-cycle collisions.
package reg_file_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  typedef logic [DEF_WIDTH-1:0] data_t;
  typedef logic [DEF_AW-1:0]    addr_t;

  localparam addr_t ZERO_REG = '0;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/reg_file_rport.sv
// One registered read port: zero/range check, optional forwarding, and the
// rdata/rvalid registers. rdata holds its last value while re is low.
module reg_file_rport
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mem [DEPTH],
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  logic             addr_ok;
  logic             bypass_hit;
  logic [WIDTH-1:0] next_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    addr_ok    = (raddr != AW'(ZERO_REG)) && (int'(raddr) < DEPTH);
    bypass_hit = addr_ok && we && (waddr == raddr);
    next_data  = '0;
    if (addr_ok) next_data = mem[raddr];
    if (BYPASS_EN && bypass_hit) next_data = wdata;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= next_data;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: one synchronous write port, two registered read ports.
// Entry 0 reads as zero. Macro REG_FILE_BYPASS_EN selects new-data forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  input  logic             re2,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid2
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage is reset explicitly because a reset must clear every entry;
  // entry 0 is never written, and out-of-range addresses match no entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (we && (waddr == AW'(i))) mem[i] <= wdata;
      end
    end
  end

  reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rport1 (
    .clk    (clk),
    .rst    (rst),
    .re     (re1),
    .raddr  (raddr1),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .mem    (mem),
    .rdata  (rdata1),
    .rvalid (rvalid1)
  );

  reg_file_rport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rport2 (
    .clk    (clk),
    .rst    (rst),
    .re     (re2),
    .raddr  (raddr2),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .mem    (mem),
    .rdata  (rdata2),
    .rvalid (rvalid2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a DEPTH=8 instance plus a DEPTH=6 instance
// sharing the same stimulus to exercise out-of-range addresses.
module tb_reg_file;
  import reg_file_pkg::*;

  logic  clk;
  logic  rst;
  logic  we;
  addr_t waddr;
  data_t wdata;
  logic  re1, re2;
  addr_t raddr1, raddr2;
  data_t rdata1, rdata2, rdata1_d6, rdata2_d6;
  logic  rvalid1, rvalid2, rvalid1_d6, rvalid2_d6;

  int n_cmp = 0;
  int n_err = 0;

  reg_file #(.WIDTH(4), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .rvalid2(rvalid2)
  );

  reg_file #(.WIDTH(4), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_d6), .rvalid1(rvalid1_d6),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_d6), .rvalid2(rvalid2_d6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] coll_exp;
    coll_exp = BYPASS_EN ? 4'h9 : 4'h1;

    // Reset held for two cycles with a write pending.
    rst = 1'b0; we = 1'b1; waddr = 3'd3; wdata = 4'hF;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    tick(); tick();
    check("rst_rvalid1", {3'b0, rvalid1}, 4'h0);
    check("rst_rvalid2", {3'b0, rvalid2}, 4'h0);
    check("rst_rdata1", rdata1, 4'h0);
    rst = 1'b1; we = 1'b0;
    tick();
    check("idle_rvalid1", {3'b0, rvalid1}, 4'h0);
    check("idle_rvalid2", {3'b0, rvalid2}, 4'h0);
    re1 = 1'b1; raddr1 = 3'd3; re2 = 1'b1; raddr2 = 3'd7;
    tick();
    check("post_rst_rd3", rdata1, 4'h0);
    check("post_rst_rv1", {3'b0, rvalid1}, 4'h1);
    check("post_rst_rd7", rdata2, 4'h0);

    // Write then read.
    re1 = 1'b0; re2 = 1'b0;
    we = 1'b1; waddr = 3'd3; wdata = 4'hA;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 3'd3;
    tick();
    check("wr_rd_data", rdata1, 4'hA);
    check("wr_rd_valid", {3'b0, rvalid1}, 4'h1);
    check("wr_rd_d6", rdata1_d6, 4'hA);

    // Entry 0 stays zero.
    re1 = 1'b0; we = 1'b1; waddr = 3'd0; wdata = 4'h5;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 3'd0;
    tick();
    check("zero_rd", rdata1, 4'h0);
    check("zero_rv", {3'b0, rvalid1}, 4'h1);

    // Address 7: in range for DEPTH=8, out of range for DEPTH=6.
    re1 = 1'b0; we = 1'b1; waddr = 3'd7; wdata = 4'hC;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 3'd3;
    tick();
    check("d6_pre_rd3", rdata1_d6, 4'hA);
    raddr1 = 3'd7;
    tick();
    check("d6_oor_rd", rdata1_d6, 4'h0);
    check("d6_oor_rv", {3'b0, rvalid1_d6}, 4'h1);
    check("d8_rd7", rdata1, 4'hC);

    // Same-cycle write/read collision on port 2.
    re1 = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 4'h1;
    tick();
    wdata = 4'h9; re2 = 1'b1; raddr2 = 3'd2;
    tick();
    check("coll_rd", rdata2, coll_exp);
    check("coll_rv", {3'b0, rvalid2}, 4'h1);
    we = 1'b0;
    tick();
    check("coll_after", rdata2, 4'h9);

    // Dual-port read, then hold with re low.
    re2 = 1'b0; we = 1'b1; waddr = 3'd5; wdata = 4'h6;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 3'd3; re2 = 1'b1; raddr2 = 3'd5;
    tick();
    check("dual_rd1", rdata1, 4'hA);
    check("dual_rd2", rdata2, 4'h6);
    check("dual_rv2", {3'b0, rvalid2}, 4'h1);
    re1 = 1'b0; re2 = 1'b0; raddr1 = 3'd5; raddr2 = 3'd3;
    tick();
    check("hold_rv1", {3'b0, rvalid1}, 4'h0);
    check("hold_rv2", {3'b0, rvalid2}, 4'h0);
    check("hold_rd1", rdata1, 4'hA);
    check("hold_rd2", rdata2, 4'h6);

    // Asynchronous reset between clock edges.
    re1 = 1'b1; raddr1 = 3'd3;
    tick();
    check("pre_arst_rv1", {3'b0, rvalid1}, 4'h1);
    check("pre_arst_rd1", rdata1, 4'hA);
    #2 rst = 1'b0;
    #1;
    check("arst_rv1", {3'b0, rvalid1}, 4'h0);
    check("arst_rd1", rdata1, 4'h0);
    #3 rst = 1'b1;
    tick();
    check("arst_mem3", rdata1, 4'h0);
    check("arst_rv_back", {3'b0, rvalid1}, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
